evt_count_ctrl: RTL and testbench

- Parametrised successor to the fixed 4-bit T0/T1/T2 counter-plus-controller pair.
- Counts qualified events on `x` after a `start` command, up to a programmable terminal value, then raises completion flag `g`.
- Adds generic width, runtime up/down mode, a latched limit, abort, and an overrun flag.
- Sits between a command source (`start`/`abort`) and an event source (`x`); `g` and `q` feed downstream control.

---
 rtl/evt_count_ctrl.sv | 105 ++++++++++
 tb/tb_evt_count_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/evt_count_ctrl.sv
// Event counter with start/abort control, programmable terminal value,
// runtime up/down direction, completion flag and sticky overrun flag.
module evt_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             x,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             g,
  output logic             busy,
  output logic [1:0]       state,
  output logic             overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RUN  = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           st;
  logic [WIDTH-1:0] lim_r;
  logic             up_r;
  logic             tc;
  logic [WIDTH-1:0] nxt_q;
  logic [WIDTH-1:0] load_q;

  // Terminal count uses only latched settings so mid-run input changes are inert
  assign tc     = up_r ? (q == lim_r) : (q == '0);
  assign nxt_q  = up_r ? q + WIDTH'(1) : q - WIDTH'(1);
  assign load_q = up_dn ? '0 : limit;
  assign state  = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      q       <= '0;
      g       <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      lim_r   <= '0;
      up_r    <= 1'b1;
    end else if (abort) begin
      st   <= IDLE;
      g    <= 1'b0;
      busy <= 1'b0;
    end else begin
      unique case (st)
        IDLE: begin
          if (start) begin
            lim_r   <= limit;
            up_r    <= up_dn;
            q       <= load_q;
            g       <= 1'b0;
            overrun <= 1'b0;
            busy    <= 1'b1;
            st      <= WAIT;
          end
        end
        WAIT: begin
          if (tc) begin
            g    <= 1'b1;
            busy <= 1'b0;
            st   <= DONE;
          end else if (x) begin
            q  <= nxt_q;
            st <= RUN;
          end
        end
        RUN: begin
          if (tc) begin
            g    <= 1'b1;
            busy <= 1'b0;
            st   <= DONE;
          end else if (x) begin
            q <= nxt_q;
          end else begin
            st <= WAIT;
          end
        end
        DONE: begin
          if (start) begin
            lim_r   <= limit;
            up_r    <= up_dn;
            q       <= load_q;
            g       <= 1'b0;
            overrun <= 1'b0;
            busy    <= 1'b1;
            st      <= WAIT;
          end else if (x) begin
            overrun <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_evt_count_ctrl.sv
// Directed bench for evt_count_ctrl: a 4-bit and an 8-bit instance
// driven through hand-computed count runs.
module tb_evt_count_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, x = 1'b0, up_dn = 1'b1;
  logic [3:0] limit = '0;
  logic [3:0] q;
  logic       g, busy, overrun;
  logic [1:0] state;

  logic       start8 = 1'b0, abort8 = 1'b0, x8 = 1'b0, up8 = 1'b1;
  logic [7:0] lim8 = '0;
  logic [7:0] q8;
  logic       g8, busy8, ovr8;
  logic [1:0] st8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  evt_count_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .x(x),
    .up_dn(up_dn), .limit(limit), .q(q), .g(g), .busy(busy),
    .state(state), .overrun(overrun)
  );

  evt_count_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8), .x(x8),
    .up_dn(up8), .limit(lim8), .q(q8), .g(g8), .busy(busy8),
    .state(st8), .overrun(ovr8)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [1:0] es,
                      input logic [3:0] eq, input logic eg,
                      input logic eb);
    chk({tag, ".state"}, 32'(state), 32'(es));
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".g"}, 32'(g), 32'(eg));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
  endtask

  initial begin
    logic       xpat [6];
    logic [1:0] spat [6];
    logic [3:0] qpat [6];
    xpat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    spat = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
    qpat = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4};

    #3;
    chk4("reset", 2'b00, 4'd0, 1'b0, 1'b0);
    chk("reset.ovr", 32'(overrun), 32'd0);
    chk("reset8.q", 32'(q8), 32'd0);
    chk("reset8.state", 32'(st8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk4("idle", 2'b00, 4'd0, 1'b0, 1'b0);

    // up, limit 5, x held high
    start = 1'b1; up_dn = 1'b1; limit = 4'd5; x = 1'b1;
    tick();
    chk4("up5.load", 2'b01, 4'd0, 1'b0, 1'b1);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk4($sformatf("up5.e%0d", i), 2'b10, 4'(i), 1'b0, 1'b1);
    end
    tick();
    chk4("up5.done", 2'b11, 4'd5, 1'b1, 1'b0);

    // down, limit 3
    start = 1'b1; up_dn = 1'b0; limit = 4'd3; x = 1'b1;
    tick();
    chk4("dn3.load", 2'b01, 4'd3, 1'b0, 1'b1);
    start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk4($sformatf("dn3.e%0d", i), 2'b10, 4'(3 - i), 1'b0, 1'b1);
    end
    tick();
    chk4("dn3.done", 2'b11, 4'd0, 1'b1, 1'b0);

    // up, limit 4, gapped events
    start = 1'b1; up_dn = 1'b1; limit = 4'd4; x = 1'b0;
    tick();
    chk4("gap.load", 2'b01, 4'd0, 1'b0, 1'b1);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      x = xpat[i];
      tick();
      chk4($sformatf("gap.e%0d", i + 1), spat[i], qpat[i], 1'b0, 1'b1);
    end
    x = 1'b0;
    tick();
    chk4("gap.done", 2'b11, 4'd4, 1'b1, 1'b0);

    // limit 0 finishes at once; overrun is sticky until restart
    start = 1'b1; up_dn = 1'b1; limit = 4'd0; x = 1'b0;
    tick();
    chk4("lim0.load", 2'b01, 4'd0, 1'b0, 1'b1);
    start = 1'b0;
    tick();
    chk4("lim0.done", 2'b11, 4'd0, 1'b1, 1'b0);
    chk("lim0.ovr0", 32'(overrun), 32'd0);
    x = 1'b1;
    tick();
    chk("lim0.ovr1", 32'(overrun), 32'd1);
    x = 1'b0;
    tick();
    chk("lim0.ovr_hold", 32'(overrun), 32'd1);
    start = 1'b1; limit = 4'd3;
    tick();
    chk4("lim0.restart", 2'b01, 4'd0, 1'b0, 1'b1);
    chk("lim0.ovr_clr", 32'(overrun), 32'd0);
    start = 1'b0;
    abort = 1'b1;
    tick();
    chk4("abort.wait", 2'b00, 4'd0, 1'b0, 1'b0);
    abort = 1'b0;

    // abort mid-run keeps q
    start = 1'b1; up_dn = 1'b1; limit = 4'd9; x = 1'b1;
    tick();
    chk4("ab9.load", 2'b01, 4'd0, 1'b0, 1'b1);
    start = 1'b0;
    tick();
    tick();
    chk4("ab9.q2", 2'b10, 4'd2, 1'b0, 1'b1);
    abort = 1'b1;
    tick();
    chk4("ab9.idle", 2'b00, 4'd2, 1'b0, 1'b0);
    abort = 1'b0; x = 1'b0;
    tick();
    chk4("ab9.hold", 2'b00, 4'd2, 1'b0, 1'b0);

    // start/limit changes mid-run ignored, then async reset at q=6
    start = 1'b1; up_dn = 1'b1; limit = 4'd9; x = 1'b1;
    tick();
    chk4("rs9.load", 2'b01, 4'd0, 1'b0, 1'b1);
    start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 3) begin
        start = 1'b1; limit = 4'd2; up_dn = 1'b0;
      end else begin
        start = 1'b0;
      end
      tick();
      chk4($sformatf("rs9.e%0d", i), 2'b10, 4'(i), 1'b0, 1'b1);
    end
    #2;
    rst = 1'b1;
    #1;
    chk4("rs9.async", 2'b00, 4'd0, 1'b0, 1'b0);
    x = 1'b0; start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // 8-bit full-range up count, limit changed mid-run
    start8 = 1'b1; up8 = 1'b1; lim8 = 8'd255; x8 = 1'b1;
    tick();
    chk("w8.load.state", 32'(st8), 32'd1);
    chk("w8.load.q", 32'(q8), 32'd0);
    start8 = 1'b0; lim8 = 8'd10;
    for (int i = 1; i <= 255; i++) begin
      tick();
      chk($sformatf("w8.e%0d.q", i), 32'(q8), 32'(i));
      chk($sformatf("w8.e%0d.g", i), 32'(g8), 32'd0);
    end
    tick();
    chk("w8.done.state", 32'(st8), 32'd3);
    chk("w8.done.q", 32'(q8), 32'd255);
    chk("w8.done.g", 32'(g8), 32'd1);
    chk("w8.done.busy", 32'(busy8), 32'd0);
    x8 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
